// File: rtl/rgb_pixel_fanout_fifo_pkg.sv
// rtl/rgb_pixel_fanout_fifo_pkg.sv - shared pixel types, default sizes and channel helper
package rgb_pixel_fanout_fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_PIX_W    = DEF_WIDTH * DEF_CHANNELS;
  localparam int DEF_LEVEL_W  = $clog2(DEF_DEPTH + 1);

  typedef logic [DEF_PIX_W-1:0] pixel_t;

  // Channel 0 sits in the LSBs (r for the default RGB layout).
  function automatic logic [DEF_WIDTH-1:0] ch_sel(input pixel_t pixel, input int i);
    return pixel[i*DEF_WIDTH +: DEF_WIDTH];
  endfunction

endpackage

// File: rtl/rgb_pixel_fanout_fifo_if.sv
// rtl/rgb_pixel_fanout_fifo_if.sv - source/dual-consumer pixel handshake bundle
interface rgb_pixel_fanout_fifo_if #(
  parameter int PIX_W   = 24,
  parameter int LEVEL_W = 3
);

  logic               in_valid;
  logic               in_ready;
  logic [PIX_W-1:0]   in_pixel;
  logic               out_a_valid;
  logic               out_a_ready;
  logic [PIX_W-1:0]   out_a_pixel;
  logic               out_b_valid;
  logic               out_b_ready;
  logic [PIX_W-1:0]   out_b_pixel;
  logic [LEVEL_W-1:0] level;

  modport slave (
    input  in_valid, in_pixel, out_a_ready, out_b_ready,
    output in_ready, out_a_valid, out_a_pixel, out_b_valid, out_b_pixel, level
  );

  modport master (
    output in_valid, in_pixel, out_a_ready, out_b_ready,
    input  in_ready, out_a_valid, out_a_pixel, out_b_valid, out_b_pixel, level
  );

endinterface

// File: rtl/rgb_pixel_fanout_fifo_core.sv
// rtl/rgb_pixel_fanout_fifo_core.sv - pixel_fifo_core: storage, wrapping pointers and fill level
module pixel_fifo_core #(
  parameter int PIX_W   = 24,
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               pop,
  output logic [PIX_W-1:0]   rd_data,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PIX_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full    = (level == LEVEL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = storage[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= wr_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/rgb_pixel_fanout_fifo.sv
// rtl/rgb_pixel_fanout_fifo.sv - FIFO-buffered pixel broadcast to two independent consumers
module rgb_pixel_fanout_fifo
  import rgb_pixel_fanout_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  rgb_pixel_fanout_fifo_if.slave  bus
);

  localparam int PIX_W   = WIDTH * CHANNELS;
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             taken_a;
  logic             taken_b;
  logic             acc_a;
  logic             acc_b;
  logic [PIX_W-1:0] head;

  // in_ready looks only at the fill level, never at the consumer readies.
  assign bus.in_ready    = !rst && !full;
  assign push            = bus.in_valid && bus.in_ready;

  assign bus.out_a_valid = !empty && !taken_a;
  assign bus.out_b_valid = !empty && !taken_b;
  assign bus.out_a_pixel = head;
  assign bus.out_b_pixel = head;

  assign acc_a = bus.out_a_valid && bus.out_a_ready;
  assign acc_b = bus.out_b_valid && bus.out_b_ready;
  assign pop   = !empty && (taken_a || acc_a) && (taken_b || acc_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_a <= 1'b0;
      taken_b <= 1'b0;
    end else if (pop) begin
      taken_a <= 1'b0;
      taken_b <= 1'b0;
    end else begin
      taken_a <= taken_a || acc_a;
      taken_b <= taken_b || acc_b;
    end
  end

  pixel_fifo_core #(
    .PIX_W   (PIX_W),
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (bus.in_pixel),
    .pop     (pop),
    .rd_data (head),
    .level   (bus.level),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_rgb_pixel_fanout_fifo.sv
// tb/tb_rgb_pixel_fanout_fifo.sv - self-checking bench with queue model of the dual-consumer FIFO
module tb_rgb_pixel_fanout_fifo;
  import rgb_pixel_fanout_fifo_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_pixel_fanout_fifo_if #(.PIX_W(24), .LEVEL_W(3)) bus ();

  rgb_pixel_fanout_fifo #(.WIDTH(8), .CHANNELS(3), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pixel_t q[$];
  bit     m_ta, m_tb, last_push;
  int     tests = 0, fails = 0;
  int     dut_acc_a = 0, dut_acc_b = 0, m_acc_a = 0, m_acc_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare();
    if (rst) begin
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_a_valid", bus.out_a_valid, 0);
      check("rst_b_valid", bus.out_b_valid, 0);
      check("rst_a_pixel", bus.out_a_pixel, 0);
      check("rst_b_pixel", bus.out_b_pixel, 0);
      check("rst_level", bus.level, 0);
    end else begin
      check("level", bus.level, q.size());
      check("in_ready", bus.in_ready, q.size() != D);
      check("a_valid", bus.out_a_valid, q.size() > 0 && !m_ta);
      check("b_valid", bus.out_b_valid, q.size() > 0 && !m_tb);
      if (q.size() > 0 && !m_ta) check("a_pixel", bus.out_a_pixel, q[0]);
      if (q.size() > 0 && !m_tb) check("b_pixel", bus.out_b_pixel, q[0]);
      check("a_eq_b_pixel", bus.out_a_pixel, bus.out_b_pixel);
      if (bus.out_a_valid && bus.out_a_ready) dut_acc_a++;
      if (bus.out_b_valid && bus.out_b_ready) dut_acc_b++;
    end
  endtask

  task automatic model_update();
    bit acc_a, acc_b, pop, push;
    int sz;
    last_push = 0;
    if (rst) return;
    sz    = q.size();
    acc_a = sz > 0 && !m_ta && bus.out_a_ready;
    acc_b = sz > 0 && !m_tb && bus.out_b_ready;
    pop   = sz > 0 && (m_ta || acc_a) && (m_tb || acc_b);
    push  = bus.in_valid && sz < D;
    m_acc_a += int'(acc_a);
    m_acc_b += int'(acc_b);
    if (pop) begin
      void'(q.pop_front());
      m_ta = 0;
      m_tb = 0;
    end else begin
      m_ta = m_ta || acc_a;
      m_tb = m_tb || acc_b;
    end
    if (push) begin
      q.push_back(bus.in_pixel);
      last_push = 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input pixel_t p, input bit ra, input bit rb);
    bus.in_valid    = v;
    bus.in_pixel    = p;
    bus.out_a_ready = ra;
    bus.out_b_ready = rb;
  endtask

  task automatic drain();
    int n = 0;
    drive(0, '0, 1, 1);
    while (q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("drain_done", q.size(), 0);
  endtask

  initial begin
    int pushed, snap_a, snap_b;
    rst = 1'b1;
    drive(0, '0, 0, 0);
    step();
    rst = 1'b0;
    step();

    // 1: single pixel, both consumers ready
    drive(1, 24'h112233, 1, 1);
    step();
    drive(0, '0, 1, 1);
    check("t1_a_valid", bus.out_a_valid, 1);
    check("t1_b_valid", bus.out_b_valid, 1);
    check("t1_pixel", bus.out_a_pixel, 24'h112233);
    check("t1_red_ch", ch_sel(bus.out_a_pixel, 0), 8'h33);
    check("t1_level1", bus.level, 1);
    step();
    check("t1_level0", bus.level, 0);
    check("t1_in_ready", bus.in_ready, 1);

    // 2: fill to DEPTH with no consumer ready
    for (int i = 1; i <= D; i++) begin
      drive(1, 24'hAA0000 + pixel_t'(i), 0, 0);
      step();
    end
    check("t2_level_full", bus.level, 4);
    check("t2_in_ready", bus.in_ready, 0);
    drive(1, 24'hAA0005, 0, 0);
    step();
    step();
    check("t2_held_level", bus.level, 4);

    // 4a: full with both ready and in_valid -> pop only, no bypass
    drive(1, 24'hAA0005, 1, 1);
    step();
    check("t4_no_bypass", bus.level, 3);
    drive(1, 24'hAA0005, 0, 0);
    step();
    drive(0, '0, 0, 0);
    check("t4_push_after", bus.level, 4);

    // 3: A accepts alone, B later
    drive(0, '0, 1, 0);
    step();
    check("t3_a_valid", bus.out_a_valid, 0);
    check("t3_b_valid", bus.out_b_valid, 1);
    check("t3_b_pixel", bus.out_b_pixel, 24'hAA0002);
    check("t3_level", bus.level, 4);
    drive(0, '0, 1, 1);
    step();
    check("t3_next_a", bus.out_a_pixel, 24'hAA0003);
    check("t3_next_valid", bus.out_a_valid, 1);
    check("t3_level3", bus.level, 3);
    drain();

    // 5: wrap with 2*DEPTH+1 sequential pixels
    for (int i = 1; i <= 2 * D + 1; i++) begin
      drive(1, pixel_t'(i), 1, 1);
      step();
    end
    check("t5_last", bus.out_a_pixel, 24'h000009);
    drain();

    // 4b: random stream of 100 pixels with random readies
    pushed = 0;
    for (int c = 0; c < 3000 && pushed < 100; c++) begin
      drive(1'($urandom_range(0, 1)), pixel_t'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      step();
      if (last_push) pushed++;
    end
    check("t4_pushed", pushed, 100);
    drain();
    check("t4_acc_a", dut_acc_a, m_acc_a);
    check("t4_acc_b", dut_acc_b, m_acc_b);

    // 6: reset mid-transfer with level 3 and A already taken
    for (int i = 0; i < 3; i++) begin
      drive(1, 24'hC00000 + pixel_t'(i), 0, 0);
      step();
    end
    drive(0, '0, 1, 0);
    step();
    drive(0, '0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_in_ready", bus.in_ready, 0);
    check("t6_a_valid", bus.out_a_valid, 0);
    check("t6_b_valid", bus.out_b_valid, 0);
    check("t6_pixel", bus.out_b_pixel, 0);
    check("t6_level", bus.level, 0);
    q.delete();
    m_ta = 0;
    m_tb = 0;
    step();
    rst = 1'b0;
    step();
    snap_a = dut_acc_a;
    snap_b = dut_acc_b;
    drive(1, 24'h5A5A5A, 1, 1);
    step();
    drive(0, '0, 1, 1);
    check("t6_new_pixel", bus.out_a_pixel, 24'h5A5A5A);
    for (int i = 0; i < 5; i++) step();
    check("t6_once_a", dut_acc_a - snap_a, 1);
    check("t6_once_b", dut_acc_b - snap_b, 1);
    check("t6_empty", bus.level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
